multi_cycle_control_unit: RTL and testbench
===========================================

# multi_cycle_control_unit

Sequencing controller for the multi-cycle RV32I datapath. Walks each instruction through fetch, decode, execute, memory and write-back states. Drives every datapath enable and mux select (PC, IR, MDR, register file, ALU operand and op selects, memory port). Handshakes with a variable-latency memory and counts retired instructions. Sits beside the datapath and consumes the IR opcode and the branch comparator result.

## Interface
- `CNT_W`, 32, width of retired-instruction counter
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high
- `opcode`  in  7  IR[6:0]
- `bcond`  in  1  branch-taken result from ALU comparator, valid in EX
- `halt_req`  in  1  datapath flag: x17 == 10, valid in ID
- `mem_ready`  in  1  memory completed current read/write this cycle
- `mem_read`, `mem_write`  out  1  memory request, held until `mem_ready`
- `i_or_d`  out  1  0 = address from PC, 1 = address from ALUOut
- `ir_write`, `mdr_write`, `reg_write`, `pc_write`  out  1  register enables
- `pc_source`  out  2  PC_PLUS4 / ALUOUT / ALU_RESULT
- `alu_src_a`  out  1  0 = PC, 1 = A
- `alu_src_b`  out  2  B / IMM / FOUR
- `alu_op`  out  2  ADD / BRANCH_CMP / FUNCT
- `wb_src`  out  2  ALUOUT / MDR / PC_PLUS4
- `illegal`  out  1  one-cycle pulse on unknown opcode
- `is_halted`  out  1  sticky halt
- `num_inst`  out  CNT_W  retired-instruction count

## Operation
- States: IF, ID, EX, MEM, WB, HALT. Unlisted outputs are 0 in every state.
- IF: `mem_read`=1, `i_or_d`=0. Stay in IF while `mem_ready`=0. On `mem_ready`: `ir_write`=1, go to ID.
- ID: ALUOut <= PC+imm (`alu_src_a`=0, `alu_src_b`=IMM, `alu_op`=ADD).
  - ECALL with `halt_req`=1: go to HALT.
  - All other opcodes: go to EX.
- EX, by opcode:
  - ARITHMETIC, ARITHMETIC_IMM: A op B/IMM, `alu_op`=FUNCT, go to WB.
  - LOAD, STORE: A+IMM, go to MEM.
  - BRANCH: BRANCH_CMP on A,B. `pc_write`=1. `pc_source`=ALUOUT if `bcond`, else PC_PLUS4. Go to IF.
  - JAL: `reg_write`=1, `wb_src`=PC_PLUS4, `pc_write`=1, `pc_source`=ALUOUT. Go to IF.
  - JALR: A+IMM, `reg_write`=1, `wb_src`=PC_PLUS4, `pc_write`=1, `pc_source`=ALU_RESULT (datapath clears bit 0). Go to IF.
  - ECALL (non-halt): `pc_write`=1, PC_PLUS4, go to IF.
  - Unknown opcode: as ECALL, plus `illegal`=1.
- MEM: `i_or_d`=1.
  - LOAD: `mem_read`=1. Wait for `mem_ready`, then `mdr_write`=1, go to WB.
  - STORE: `mem_write`=1. Wait for `mem_ready`, then `pc_write`=1 (PC_PLUS4), go to IF.
- WB: `reg_write`=1, `wb_src`=MDR for LOAD else ALUOUT. `pc_write`=1, PC_PLUS4. Go to IF.
- HALT: absorbing until reset. `is_halted`=1. All enables 0, memory idle.
- Retire: `num_inst` increments by 1 in every cycle where `pc_write`=1. It wraps modulo 2^CNT_W. HALT entry does not count.

## Timing
- Reset asserted: state=IF, `num_inst`=0, `is_halted`=0. All outputs forced 0 while `reset`=1.
- First fetch request appears the first cycle after reset deasserts.
- State register updates on `clk` rising edge. Outputs are combinational from state, `opcode`, `mem_ready` and `bcond`.
- Cycle counts with `mem_ready` tied 1:
  - branch, JAL, JALR, ECALL: 3
  - ALU ops, STORE: 4
  - LOAD: 5
- Each cycle `mem_ready` stays low adds one cycle in IF or MEM.
- `mem_read`/`mem_write` never deassert before `mem_ready` in the same state. A stray `mem_ready` outside IF/MEM is ignored.
- Reset mid-instruction, including during a memory wait: return to IF immediately, and no write enable is emitted in that cycle.
- Only `ir_write`, `mdr_write`, `pc_write`, `reg_write` are capture points. Each is asserted at most one cycle per instruction.

## Structure
- Shared package `control_pkg` holds:
  - opcode constants: ARITHMETIC, ARITHMETIC_IMM, LOAD, STORE, BRANCH, JAL, JALR, ECALL
  - state enum
  - `pc_source`, `alu_src_b`, `alu_op`, `wb_src` encodings
- Opcode constants are shared with the immediate generator and ALU control.
- Sub-module `control_output_decoder`: purely combinational (state, opcode, mem_ready, bcond) → control vector.
- Top level holds the state register, next-state logic, halt flag and counter.

## Test plan
- R-type ADD, `mem_ready`=1: states IF,ID,EX,WB. `reg_write` only in WB, `wb_src`=ALUOUT. `num_inst` 0→1 after 4 cycles.
- LOAD, `mem_ready` low 2 cycles in IF and 3 in MEM: 10 cycles total. `mem_read` held throughout the waits. `mdr_write` exactly once, then WB with `wb_src`=MDR.
- BRANCH with `bcond`=1 then 0: `pc_source`=ALUOUT then PC_PLUS4. Each takes 3 cycles, `reg_write` never asserted.
- ECALL with `halt_req`=1: HALT after ID, `is_halted`=1 held for 20 cycles, `num_inst` unchanged. Then `reset` → `is_halted`=0, state IF.
- `reset` pulse during STORE MEM wait: `mem_write` drops during reset, no `pc_write`, fetch restarts, counter=0.
- Counter with CNT_W=4: 16 retires wrap `num_inst` 15→0.

Source files
------------

// File: rtl/control_pkg.sv
// Shared opcode constants, state encoding and datapath control vector for the
// multi-cycle RV32I controller, immediate generator and ALU control.
package control_pkg;

    localparam int unsigned OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] ARITHMETIC     = 7'b0110011;
    localparam logic [OPCODE_W-1:0] ARITHMETIC_IMM = 7'b0010011;
    localparam logic [OPCODE_W-1:0] LOAD           = 7'b0000011;
    localparam logic [OPCODE_W-1:0] STORE          = 7'b0100011;
    localparam logic [OPCODE_W-1:0] BRANCH         = 7'b1100011;
    localparam logic [OPCODE_W-1:0] JAL            = 7'b1101111;
    localparam logic [OPCODE_W-1:0] JALR           = 7'b1100111;
    localparam logic [OPCODE_W-1:0] ECALL          = 7'b1110011;

    localparam logic [1:0] PCSRC_PC_PLUS4   = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT     = 2'd1;
    localparam logic [1:0] PCSRC_ALU_RESULT = 2'd2;

    localparam logic [1:0] SRCB_B    = 2'd0;
    localparam logic [1:0] SRCB_IMM  = 2'd1;
    localparam logic [1:0] SRCB_FOUR = 2'd2;

    localparam logic [1:0] ALUOP_ADD        = 2'd0;
    localparam logic [1:0] ALUOP_BRANCH_CMP = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT      = 2'd2;

    localparam logic [1:0] WB_ALUOUT   = 2'd0;
    localparam logic [1:0] WB_MDR      = 2'd1;
    localparam logic [1:0] WB_PC_PLUS4 = 2'd2;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_t;

    typedef struct packed {
        logic       mem_read;
        logic       mem_write;
        logic       i_or_d;
        logic       ir_write;
        logic       mdr_write;
        logic       reg_write;
        logic       pc_write;
        logic [1:0] pc_source;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] wb_src;
        logic       illegal;
    } ctrl_t;

    function automatic logic is_alu_opcode(input logic [OPCODE_W-1:0] op);
        return (op == ARITHMETIC) || (op == ARITHMETIC_IMM);
    endfunction

    function automatic logic is_mem_opcode(input logic [OPCODE_W-1:0] op);
        return (op == LOAD) || (op == STORE);
    endfunction

endpackage

// File: rtl/control_output_decoder.sv
// Combinational decode of FSM state, opcode, memory handshake and branch
// outcome into the full datapath control vector.
module control_output_decoder
    import control_pkg::*;
(
    input  state_t                state,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic                  mem_ready,
    input  logic                  bcond,
    output ctrl_t                 ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_IF: begin
                ctrl.mem_read = 1'b1;
                ctrl.ir_write = mem_ready;
            end
            // ID precomputes the PC-relative target into ALUOut
            S_ID: begin
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALUOP_ADD;
            end
            S_EX: begin
                case (opcode)
                    ARITHMETIC: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = SRCB_B;
                        ctrl.alu_op    = ALUOP_FUNCT;
                    end
                    ARITHMETIC_IMM: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.alu_op    = ALUOP_FUNCT;
                    end
                    LOAD, STORE: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.alu_op    = ALUOP_ADD;
                    end
                    BRANCH: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = SRCB_B;
                        ctrl.alu_op    = ALUOP_BRANCH_CMP;
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_source = bcond ? PCSRC_ALUOUT : PCSRC_PC_PLUS4;
                    end
                    JAL: begin
                        ctrl.reg_write = 1'b1;
                        ctrl.wb_src    = WB_PC_PLUS4;
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_source = PCSRC_ALUOUT;
                    end
                    JALR: begin
                        ctrl.alu_src_a = 1'b1;
                        ctrl.alu_src_b = SRCB_IMM;
                        ctrl.alu_op    = ALUOP_ADD;
                        ctrl.reg_write = 1'b1;
                        ctrl.wb_src    = WB_PC_PLUS4;
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_source = PCSRC_ALU_RESULT;
                    end
                    ECALL: begin
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_source = PCSRC_PC_PLUS4;
                    end
                    default: begin
                        ctrl.pc_write  = 1'b1;
                        ctrl.pc_source = PCSRC_PC_PLUS4;
                        ctrl.illegal   = 1'b1;
                    end
                endcase
            end
            // only loads and stores reach MEM
            S_MEM: begin
                ctrl.i_or_d = 1'b1;
                if (opcode == LOAD) begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.mdr_write = mem_ready;
                end else begin
                    ctrl.mem_write = 1'b1;
                    ctrl.pc_write  = mem_ready;
                    ctrl.pc_source = PCSRC_PC_PLUS4;
                end
            end
            S_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.wb_src    = (opcode == LOAD) ? WB_MDR : WB_ALUOUT;
                ctrl.pc_write  = 1'b1;
                ctrl.pc_source = PCSRC_PC_PLUS4;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multi_cycle_control_unit.sv
// Multi-cycle RV32I sequencing controller: state register, next-state logic,
// sticky halt flag and retired-instruction counter around the output decoder.
module multi_cycle_control_unit
    import control_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                bcond,
    input  logic                halt_req,
    input  logic                mem_ready,
    output logic                mem_read,
    output logic                mem_write,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                mdr_write,
    output logic                reg_write,
    output logic                pc_write,
    output logic [1:0]          pc_source,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic [1:0]          wb_src,
    output logic                illegal,
    output logic                is_halted,
    output logic [CNT_W-1:0]    num_inst
);

    state_t             state_q, state_d;
    logic               halted_q, halted_d;
    logic [CNT_W-1:0]   num_inst_q, num_inst_d;
    ctrl_t              ctrl;
    ctrl_t              ctrl_out;

    control_output_decoder u_decoder (
        .state     (state_q),
        .opcode    (opcode),
        .mem_ready (mem_ready),
        .bcond     (bcond),
        .ctrl      (ctrl)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IF:   if (mem_ready) state_d = S_ID;
            S_ID:   state_d = ((opcode == ECALL) && halt_req) ? S_HALT : S_EX;
            S_EX: begin
                if (is_alu_opcode(opcode))      state_d = S_WB;
                else if (is_mem_opcode(opcode)) state_d = S_MEM;
                else                            state_d = S_IF;
            end
            S_MEM:  if (mem_ready) state_d = (opcode == LOAD) ? S_WB : S_IF;
            S_WB:   state_d = S_IF;
            S_HALT: state_d = S_HALT;
            default: state_d = S_IF;
        endcase
    end

    // every PC update retires exactly one instruction
    always_comb begin
        halted_d   = halted_q | (state_d == S_HALT);
        num_inst_d = num_inst_q + CNT_W'(ctrl.pc_write);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IF;
            halted_q   <= 1'b0;
            num_inst_q <= '0;
        end else begin
            state_q    <= state_d;
            halted_q   <= halted_d;
            num_inst_q <= num_inst_d;
        end
    end

    // reset kills every enable combinationally, even mid memory wait
    assign ctrl_out  = reset ? '0 : ctrl;

    assign mem_read  = ctrl_out.mem_read;
    assign mem_write = ctrl_out.mem_write;
    assign i_or_d    = ctrl_out.i_or_d;
    assign ir_write  = ctrl_out.ir_write;
    assign mdr_write = ctrl_out.mdr_write;
    assign reg_write = ctrl_out.reg_write;
    assign pc_write  = ctrl_out.pc_write;
    assign pc_source = ctrl_out.pc_source;
    assign alu_src_a = ctrl_out.alu_src_a;
    assign alu_src_b = ctrl_out.alu_src_b;
    assign alu_op    = ctrl_out.alu_op;
    assign wb_src    = ctrl_out.wb_src;
    assign illegal   = ctrl_out.illegal;
    assign is_halted = halted_q & ~reset;
    assign num_inst  = reset ? '0 : num_inst_q;

endmodule

// File: tb/tb_multi_cycle_control_unit.sv
// Directed testbench for multi_cycle_control_unit: per-cycle control vector,
// state and counter checks, plus a 4-bit counter instance for wraparound.
module tb_multi_cycle_control_unit;
    import control_pkg::*;

    // control vector layout: {mr,mw,iod,irw,mdrw,rw,pcw,pcs[2],asa,asb[2],aop[2],wb[2],ill}
    localparam logic [16:0] F_MR       = 17'h10000;
    localparam logic [16:0] F_MW       = 17'h08000;
    localparam logic [16:0] F_IOD      = 17'h04000;
    localparam logic [16:0] F_IRW      = 17'h02000;
    localparam logic [16:0] F_MDRW     = 17'h01000;
    localparam logic [16:0] F_RW       = 17'h00800;
    localparam logic [16:0] F_PCW      = 17'h00400;
    localparam logic [16:0] PCS_ALUOUT = 17'h00100;
    localparam logic [16:0] PCS_ALURES = 17'h00200;
    localparam logic [16:0] F_ASA      = 17'h00080;
    localparam logic [16:0] ASB_IMM    = 17'h00020;
    localparam logic [16:0] AOP_CMP    = 17'h00008;
    localparam logic [16:0] AOP_FUNCT  = 17'h00010;
    localparam logic [16:0] WB_MDRV    = 17'h00002;
    localparam logic [16:0] WB_PC4     = 17'h00004;
    localparam logic [16:0] F_ILL      = 17'h00001;

    localparam logic [16:0] C_IFW     = F_MR;
    localparam logic [16:0] C_IFG     = F_MR | F_IRW;
    localparam logic [16:0] C_ID      = ASB_IMM;
    localparam logic [16:0] C_EX_R    = F_ASA | AOP_FUNCT;
    localparam logic [16:0] C_EX_I    = F_ASA | ASB_IMM | AOP_FUNCT;
    localparam logic [16:0] C_EX_M    = F_ASA | ASB_IMM;
    localparam logic [16:0] C_EX_BT   = F_PCW | PCS_ALUOUT | F_ASA | AOP_CMP;
    localparam logic [16:0] C_EX_BN   = F_PCW | F_ASA | AOP_CMP;
    localparam logic [16:0] C_EX_JAL  = F_RW | F_PCW | PCS_ALUOUT | WB_PC4;
    localparam logic [16:0] C_EX_JALR = F_RW | F_PCW | PCS_ALURES | F_ASA | ASB_IMM | WB_PC4;
    localparam logic [16:0] C_EX_EC   = F_PCW;
    localparam logic [16:0] C_EX_ILL  = F_PCW | F_ILL;
    localparam logic [16:0] C_MEM_LW  = F_MR | F_IOD;
    localparam logic [16:0] C_MEM_LG  = F_MR | F_IOD | F_MDRW;
    localparam logic [16:0] C_MEM_SW  = F_MW | F_IOD;
    localparam logic [16:0] C_MEM_SG  = F_MW | F_IOD | F_PCW;
    localparam logic [16:0] C_WB_R    = F_RW | F_PCW;
    localparam logic [16:0] C_WB_L    = F_RW | F_PCW | WB_MDRV;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_SYS   = 7'b1110011;
    localparam logic [6:0] OPC_BAD   = 7'b1111111;

    logic        clk, reset;
    logic [6:0]  opcode;
    logic        bcond, halt_req, mem_ready;

    logic        mem_read, mem_write, i_or_d, ir_write, mdr_write, reg_write, pc_write;
    logic [1:0]  pc_source, alu_src_b, alu_op, wb_src;
    logic        alu_src_a, illegal, is_halted;
    logic [31:0] num_inst;

    logic        mem_read4, mem_write4, i_or_d4, ir_write4, mdr_write4, reg_write4, pc_write4;
    logic [1:0]  pc_source4, alu_src_b4, alu_op4, wb_src4;
    logic        alu_src_a4, illegal4, is_halted4;
    logic [3:0]  num_inst4;

    logic [16:0] obs, obs4;
    assign obs  = {mem_read, mem_write, i_or_d, ir_write, mdr_write, reg_write, pc_write,
                   pc_source, alu_src_a, alu_src_b, alu_op, wb_src, illegal};
    assign obs4 = {mem_read4, mem_write4, i_or_d4, ir_write4, mdr_write4, reg_write4, pc_write4,
                   pc_source4, alu_src_a4, alu_src_b4, alu_op4, wb_src4, illegal4};

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    multi_cycle_control_unit #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
        .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
        .ir_write(ir_write), .mdr_write(mdr_write), .reg_write(reg_write), .pc_write(pc_write),
        .pc_source(pc_source), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .wb_src(wb_src), .illegal(illegal), .is_halted(is_halted), .num_inst(num_inst)
    );

    multi_cycle_control_unit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
        .mem_ready(mem_ready), .mem_read(mem_read4), .mem_write(mem_write4), .i_or_d(i_or_d4),
        .ir_write(ir_write4), .mdr_write(mdr_write4), .reg_write(reg_write4), .pc_write(pc_write4),
        .pc_source(pc_source4), .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_op(alu_op4),
        .wb_src(wb_src4), .illegal(illegal4), .is_halted(is_halted4), .num_inst(num_inst4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // tasks start and end at posedge+1; outputs are sampled 3 time units later
    task automatic test_reset();
        reset = 1'b1; opcode = OPC_R; bcond = 1'b1; halt_req = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== 17'h0 || dut.state_q !== S_IF || num_inst !== 32'd0 || is_halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: ctrl=%h state=%0d cnt=%0d halted=%b, expected ctrl=0 state=%0d cnt=0 halted=0",
                     obs, dut.state_q, num_inst, is_halted, S_IF);
        end
        reset = 1'b0; mem_ready = 1'b0; bcond = 1'b0;
        #3;
        checks++;
        if (obs !== C_IFW || dut.state_q !== S_IF) begin
            errors++;
            $display("FAIL first_fetch: ctrl=%h state=%0d, expected ctrl=%h state=%0d", obs, dut.state_q, C_IFW, S_IF);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_alu();
        logic [6:0]  ops [2] = '{OPC_R, OPC_I};
        logic [16:0] exs [2] = '{C_EX_R, C_EX_I};
        state_t      es  [4] = '{S_IF, S_ID, S_EX, S_WB};
        for (int k = 0; k < 2; k++) begin
            logic [16:0] ev [4] = '{C_IFG, C_ID, exs[k], C_WB_R};
            opcode = ops[k]; mem_ready = 1'b1; bcond = 1'b0; halt_req = 1'b0;
            for (int i = 0; i < 4; i++) begin
                #3;
                checks++;
                if (obs !== ev[i] || dut.state_q !== es[i]) begin
                    errors++;
                    $display("FAIL alu op%0d cyc%0d: ctrl=%h state=%0d, expected ctrl=%h state=%0d",
                             k, i, obs, dut.state_q, ev[i], es[i]);
                end
                @(posedge clk); #1;
            end
            exp_cnt++;
            checks++;
            if (num_inst !== exp_cnt) begin
                errors++;
                $display("FAIL alu_count op%0d: got %0d, expected %0d", k, num_inst, exp_cnt);
            end
        end
    endtask

    task automatic test_load();
        logic [16:0] ev [10] = '{C_IFW, C_IFW, C_IFG, C_ID, C_EX_M,
                                  C_MEM_LW, C_MEM_LW, C_MEM_LW, C_MEM_LG, C_WB_L};
        state_t      es [10] = '{S_IF, S_IF, S_IF, S_ID, S_EX, S_MEM, S_MEM, S_MEM, S_MEM, S_WB};
        logic        mr [10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        opcode = OPC_LOAD; bcond = 1'b0; halt_req = 1'b0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = mr[i];
            #3;
            checks++;
            if (obs !== ev[i] || dut.state_q !== es[i]) begin
                errors++;
                $display("FAIL load cyc%0d: ctrl=%h state=%0d, expected ctrl=%h state=%0d",
                         i, obs, dut.state_q, ev[i], es[i]);
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        checks++;
        if (num_inst !== exp_cnt || dut.state_q !== S_IF) begin
            errors++;
            $display("FAIL load_done: cnt=%0d state=%0d, expected cnt=%0d state=%0d", num_inst, dut.state_q, exp_cnt, S_IF);
        end
    endtask

    task automatic test_branch();
        logic        bc  [2] = '{1'b1, 1'b0};
        logic [16:0] exs [2] = '{C_EX_BT, C_EX_BN};
        state_t      es  [3] = '{S_IF, S_ID, S_EX};
        for (int k = 0; k < 2; k++) begin
            logic [16:0] ev [3] = '{C_IFG, C_ID, exs[k]};
            opcode = OPC_BR; mem_ready = 1'b1; halt_req = 1'b0; bcond = bc[k];
            for (int i = 0; i < 3; i++) begin
                #3;
                checks++;
                if (obs !== ev[i] || dut.state_q !== es[i]) begin
                    errors++;
                    $display("FAIL branch bcond=%b cyc%0d: ctrl=%h state=%0d, expected ctrl=%h state=%0d",
                             bc[k], i, obs, dut.state_q, ev[i], es[i]);
                end
                @(posedge clk); #1;
            end
            exp_cnt++;
            checks++;
            if (num_inst !== exp_cnt || dut.state_q !== S_IF) begin
                errors++;
                $display("FAIL branch_done bcond=%b: cnt=%0d state=%0d, expected cnt=%0d state=%0d",
                         bc[k], num_inst, dut.state_q, exp_cnt, S_IF);
            end
        end
        bcond = 1'b0;
    endtask

    task automatic test_jumps();
        logic [6:0]  ops [4] = '{OPC_JAL, OPC_JALR, OPC_SYS, OPC_BAD};
        logic [16:0] exs [4] = '{C_EX_JAL, C_EX_JALR, C_EX_EC, C_EX_ILL};
        state_t      es  [3] = '{S_IF, S_ID, S_EX};
        for (int k = 0; k < 4; k++) begin
            logic [16:0] ev [3] = '{C_IFG, C_ID, exs[k]};
            opcode = ops[k]; mem_ready = 1'b1; halt_req = 1'b0; bcond = 1'b0;
            for (int i = 0; i < 3; i++) begin
                #3;
                checks++;
                if (obs !== ev[i] || dut.state_q !== es[i]) begin
                    errors++;
                    $display("FAIL jump op=%b cyc%0d: ctrl=%h state=%0d, expected ctrl=%h state=%0d",
                             ops[k], i, obs, dut.state_q, ev[i], es[i]);
                end
                @(posedge clk); #1;
            end
            exp_cnt++;
            checks++;
            if (num_inst !== exp_cnt) begin
                errors++;
                $display("FAIL jump_count op=%b: got %0d, expected %0d", ops[k], num_inst, exp_cnt);
            end
        end
    endtask

    task automatic test_store();
        logic [16:0] ev [5] = '{C_IFG, C_ID, C_EX_M, C_MEM_SW, C_MEM_SG};
        state_t      es [5] = '{S_IF, S_ID, S_EX, S_MEM, S_MEM};
        logic        mr [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        opcode = OPC_STORE; bcond = 1'b0; halt_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ready = mr[i];
            #3;
            checks++;
            if (obs !== ev[i] || dut.state_q !== es[i]) begin
                errors++;
                $display("FAIL store cyc%0d: ctrl=%h state=%0d, expected ctrl=%h state=%0d",
                         i, obs, dut.state_q, ev[i], es[i]);
            end
            @(posedge clk); #1;
        end
        exp_cnt++;
        checks++;
        if (num_inst !== exp_cnt || dut.state_q !== S_IF) begin
            errors++;
            $display("FAIL store_done: cnt=%0d state=%0d, expected cnt=%0d state=%0d", num_inst, dut.state_q, exp_cnt, S_IF);
        end
    endtask

    task automatic test_reset_mid_store();
        logic [16:0] ev [4] = '{C_IFG, C_ID, C_EX_M, C_MEM_SW};
        state_t      es [4] = '{S_IF, S_ID, S_EX, S_MEM};
        logic        mr [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        opcode = OPC_STORE; bcond = 1'b0; halt_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = mr[i];
            #3;
            checks++;
            if (obs !== ev[i] || dut.state_q !== es[i]) begin
                errors++;
                $display("FAIL midrst cyc%0d: ctrl=%h state=%0d, expected ctrl=%h state=%0d",
                         i, obs, dut.state_q, ev[i], es[i]);
            end
            if (i < 3) begin
                @(posedge clk); #1;
            end
        end
        reset = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if (obs !== 17'h0 || dut.state_q !== S_IF || num_inst !== 32'd0) begin
            errors++;
            $display("FAIL midrst_assert: ctrl=%h state=%0d cnt=%0d, expected ctrl=0 state=%0d cnt=0",
                     obs, dut.state_q, num_inst, S_IF);
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        exp_cnt = 32'd0;
        #3;
        checks++;
        if (obs !== C_IFW || dut.state_q !== S_IF || num_inst !== exp_cnt) begin
            errors++;
            $display("FAIL midrst_refetch: ctrl=%h state=%0d cnt=%0d, expected ctrl=%h state=%0d cnt=0",
                     obs, dut.state_q, num_inst, C_IFW, S_IF);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_counter_wrap();
        logic [16:0] ev [3] = '{C_IFG, C_ID, C_EX_JAL};
        logic [3:0]  w;
        opcode = OPC_JAL; mem_ready = 1'b1; halt_req = 1'b0; bcond = 1'b0;
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < 3; i++) begin
                #3;
                checks++;
                if (obs !== ev[i] || obs4 !== ev[i]) begin
                    errors++;
                    $display("FAIL wrap_ctrl ins%0d cyc%0d: ctrl=%h ctrl4=%h, expected %h", k, i, obs, obs4, ev[i]);
                end
                @(posedge clk); #1;
            end
            exp_cnt++;
            w = 4'(k + 1);
            checks++;
            if (num_inst4 !== w || num_inst !== exp_cnt) begin
                errors++;
                $display("FAIL wrap_count ins%0d: cnt4=%0d cnt32=%0d, expected cnt4=%0d cnt32=%0d",
                         k, num_inst4, num_inst, w, exp_cnt);
            end
        end
    endtask

    task automatic test_halt();
        logic [16:0] ev [2] = '{C_IFG, C_ID};
        state_t      es [2] = '{S_IF, S_ID};
        opcode = OPC_SYS; mem_ready = 1'b1; halt_req = 1'b1; bcond = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            checks++;
            if (obs !== ev[i] || dut.state_q !== es[i]) begin
                errors++;
                $display("FAIL halt_entry cyc%0d: ctrl=%h state=%0d, expected ctrl=%h state=%0d",
                         i, obs, dut.state_q, ev[i], es[i]);
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 20; i++) begin
            mem_ready = i[0];
            #3;
            checks++;
            if (obs !== 17'h0 || obs4 !== 17'h0 || dut.state_q !== S_HALT || is_halted !== 1'b1
                || is_halted4 !== 1'b1 || num_inst !== exp_cnt) begin
                errors++;
                $display("FAIL halt_hold cyc%0d: ctrl=%h state=%0d halted=%b/%b cnt=%0d, expected ctrl=0 state=%0d halted=1 cnt=%0d",
                         i, obs, dut.state_q, is_halted, is_halted4, num_inst, S_HALT, exp_cnt);
            end
            @(posedge clk); #1;
        end
        reset = 1'b1; halt_req = 1'b0;
        #3;
        checks++;
        if (is_halted !== 1'b0 || dut.state_q !== S_IF || obs !== 17'h0 || num_inst !== 32'd0) begin
            errors++;
            $display("FAIL halt_reset: halted=%b state=%0d ctrl=%h cnt=%0d, expected halted=0 state=%0d ctrl=0 cnt=0",
                     is_halted, dut.state_q, obs, num_inst, S_IF);
        end
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b0;
        exp_cnt = 32'd0;
        #3;
        checks++;
        if (obs !== C_IFW || dut.state_q !== S_IF || is_halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_restart: ctrl=%h state=%0d halted=%b, expected ctrl=%h state=%0d halted=0",
                     obs, dut.state_q, is_halted, C_IFW, S_IF);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_jumps();
        test_store();
        test_reset_mid_store();
        test_counter_wrap();
        test_halt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
